// File: rtl/counter_pkg.sv
// Shared counter types and constants for the loadable up counter.
package counter_pkg;
    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RST = '0;
    localparam cnt_t CNT_MAX = '1;
endpackage

// File: rtl/modport_counter.sv
// Loadable free-running up counter: sync reset beats load beats increment.
// The output is the register itself, so no input reaches data_out combinationally.
module modport_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;

    // Increment wraps naturally at WIDTH bits; no carry out is kept.
    always_comb begin
        cnt_nxt = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        if (load) begin
            cnt_nxt = data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign data_out = cnt_q;

`ifdef MODPORT_COUNTER_SVA
    a_rst  : assert property (@(posedge clock) rst |=> data_out == '0);
    a_load : assert property (@(posedge clock) (load && !rst) |=> data_out == $past(data_in));
    a_inc  : assert property (@(posedge clock) (!load && !rst)
                              |=> data_out == WIDTH'($past(data_out) + 1'b1));
`endif

endmodule

// File: tb/tb_modport_counter.sv
// Bench for modport_counter: directed vector table, hand sequences, random run.
module tb_modport_counter;
    import counter_pkg::*;

    typedef struct {
        logic  rst;
        logic  load;
        cnt_t  din;
        cnt_t  exp;
        string nm;
    } vec_t;

    logic clock;
    logic rst;
    logic load;
    cnt_t data_in;
    cnt_t data_out;

    int   checks;
    int   errors;
    cnt_t model_q;
    cnt_t sb_q[$];
    vec_t vecs[$];

    modport_counter #(.WIDTH(CNT_W)) dut (
        .clock   (clock),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input cnt_t act, input cnt_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, predict via the reference model, compare after the edge.
    task automatic step(input logic r, input logic l, input cnt_t d, input string nm, output cnt_t got);
        cnt_t e;
        rst     = r;
        load    = l;
        data_in = d;
        if (r)      model_q = CNT_RST;
        else if (l) model_q = d;
        else        model_q = model_q + 1'b1;
        sb_q.push_back(model_q);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", nm);
            e = 'x;
        end else begin
            e = sb_q.pop_front();
        end
        check({nm, "/sb"}, data_out, e);
        got = data_out;
    endtask

    task automatic add(input logic r, input logic l, input cnt_t d, input cnt_t e, input string nm);
        vec_t v;
        v.rst = r; v.load = l; v.din = d; v.exp = e; v.nm = nm;
        vecs.push_back(v);
    endtask

    initial begin
        cnt_t got;
        cnt_t hold_v;
        checks  = 0;
        errors  = 0;
        model_q = CNT_RST;
        rst     = 1'b1;
        load    = 1'b1;
        data_in = 4'hA;
        #1;

        // Reset with load asserted, then free count through the wrap
        add(1'b1, 1'b1, 4'hA, 4'h0, "reset0");
        add(1'b1, 1'b1, 4'hA, 4'h0, "reset1");
        for (int i = 1; i <= 20; i++) add(1'b0, 1'b0, 4'h3, cnt_t'(i % 16), "freecount");
        add(1'b0, 1'b1, 4'h7, 4'h7, "load7");
        add(1'b0, 1'b0, 4'h0, 4'h8, "load7_inc1");
        add(1'b0, 1'b0, 4'h0, 4'h9, "load7_inc2");
        add(1'b0, 1'b0, 4'h0, 4'hA, "load7_inc3");
        add(1'b0, 1'b1, 4'hF, 4'hF, "loadF");
        add(1'b0, 1'b0, 4'h0, 4'h0, "loadF_wrap");
        add(1'b0, 1'b0, 4'h0, 4'h1, "loadF_inc");
        add(1'b1, 1'b1, 4'h5, 4'h0, "rst_over_load");
        add(1'b0, 1'b1, 4'hC, 4'hC, "load_after_rst");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].din, vecs[i].nm, got);
            check({vecs[i].nm, "/tbl"}, got, vecs[i].exp);
        end

        // Reset mid-count: count 1..9, reset, resume at 1, 2
        step(1'b1, 1'b0, 4'h0, "mid_pre", got);
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 4'h0, "mid_count", got);
        check("mid_at9", got, 4'h9);
        step(1'b1, 1'b0, 4'h0, "mid_rst", got);
        check("mid_rst0", got, 4'h0);
        step(1'b0, 1'b0, 4'h0, "mid_res1", got);
        check("mid_res1", got, 4'h1);
        step(1'b0, 1'b0, 4'h0, "mid_res2", got);
        check("mid_res2", got, 4'h2);

        // Loading the current value holds for that cycle
        hold_v = got;
        step(1'b0, 1'b1, hold_v, "hold", got);
        check("hold_same", got, 4'h2);
        step(1'b0, 1'b0, 4'h0, "hold_next", got);
        check("hold_next", got, 4'h3);

        // Multi-cycle reset stays at zero, then first load wins
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'h6, "long_rst", got);
            check("long_rst0", got, 4'h0);
        end
        step(1'b0, 1'b1, 4'hB, "post_rst_load", got);
        check("post_rst_load", got, 4'hB);

        // Random traffic checked against the scoreboard model
        for (int i = 0; i < 1200; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 cnt_t'($urandom_range(0, 15)), "rand", got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
